// File: rtl/regfile_wr_arbiter.sv
// Single write-port owner for the 32x32 register file: zero-clears every register
// after reset, then round-robin arbitrates three valid/ready requesters onto the port.
module regfile_wr_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              req2_valid,
    input  logic [ADDR_W-1:0] req2_addr,
    input  logic [DATA_W-1:0] req2_data,
    output logic              req2_ready,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        grant_id,
    output logic              init_done
);

    // Handshake: a requester's write is taken on any rising edge where its valid
    // and ready are both high. ready is combinational, only ever asserted for one
    // valid requester, and never during reset or the clear sequence.

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W:0]   clr_cnt;
    logic [1:0]        rr_ptr;

    logic [2:0]        valid_vec;
    logic              arb_en;
    logic              win_valid;
    logic [1:0]        win_id;
    logic [2:0]        idx_sum;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign valid_vec = {req2_valid, req1_valid, req0_valid};
    assign arb_en    = (state == ARB) && !reset;

    // Search starts at rr_ptr and wraps 0->1->2->0; first valid found wins.
    always_comb begin
        win_valid = 1'b0;
        win_id    = 2'd0;
        idx_sum   = 3'd0;
        idx       = 2'd0;
        for (int i = 0; i < 3; i++) begin
            idx_sum = {1'b0, rr_ptr} + 3'(i);
            idx     = (idx_sum >= 3'd3) ? 2'(idx_sum - 3'd3) : idx_sum[1:0];
            if (!win_valid && valid_vec[idx]) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        sel_addr = req0_addr;
        sel_data = req0_data;
        case (win_id)
            2'd1: begin
                sel_addr = req1_addr;
                sel_data = req1_data;
            end
            2'd2: begin
                sel_addr = req2_addr;
                sel_data = req2_data;
            end
            default: begin
                sel_addr = req0_addr;
                sel_data = req0_data;
            end
        endcase
    end

    assign req0_ready = arb_en && win_valid && (win_id == 2'd0);
    assign req1_ready = arb_en && win_valid && (win_id == 2'd1);
    assign req2_ready = arb_en && win_valid && (win_id == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            rr_ptr    <= 2'd0;
            wen       <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            grant_id  <= 2'd0;
            init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    wen      <= 1'b1;
                    waddr    <= clr_cnt[ADDR_W-1:0];
                    wdata    <= '0;
                    grant_id <= 2'd3;
                    clr_cnt  <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        state     <= ARB;
                        init_done <= 1'b1;
                    end
                end
                ARB: begin
                    if (win_valid) begin
                        // r0 is hard-wired zero: accept the request but drop the write.
                        wen      <= (sel_addr != '0);
                        waddr    <= sel_addr;
                        wdata    <= sel_data;
                        grant_id <= win_id;
                        rr_ptr   <= (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;
                    end else begin
                        wen <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: clear sequence, a vector table of
// arbitration cases, and hand-written reset/clear corner sequences.
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid, req2_valid;
    logic [4:0]  req0_addr, req1_addr, req2_addr;
    logic [31:0] req0_data, req1_data, req2_data;
    logic        req0_ready, req1_ready, req2_ready;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  grant_id;
    logic        init_done;

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct {
        string       name;
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  exp_ready;
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_gid;
    } vec_t;

    vec_t vecs[$];

    regfile_wr_arbiter #(.ADDR_W(5), .DATA_W(32), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .req2_valid(req2_valid), .req2_addr(req2_addr), .req2_data(req2_data), .req2_ready(req2_ready),
        .wen(wen), .waddr(waddr), .wdata(wdata), .grant_id(grant_id), .init_done(init_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic set_reqs(input logic [2:0] v,
                            input logic [4:0] a0, input logic [31:0] d0,
                            input logic [4:0] a1, input logic [31:0] d1,
                            input logic [4:0] a2, input logic [31:0] d2);
        req0_valid = v[0]; req0_addr = a0; req0_data = d0;
        req1_valid = v[1]; req1_addr = a1; req1_data = d1;
        req2_valid = v[2]; req2_addr = a2; req2_data = d2;
    endtask

    function automatic logic [31:0] readies();
        return {29'd0, req2_ready, req1_ready, req0_ready};
    endfunction

    // Clear phase after reset release: edge k+1 registers waddr=k.
    task automatic run_clear(input string tag, input logic [2:0] ready_at_end);
        for (int k = 0; k < 32; k++) begin
            tick();
            chk({tag, "_clr_wen"}, 32'(wen), 32'd1);
            chk({tag, "_clr_waddr"}, 32'(waddr), 32'(k));
            chk({tag, "_clr_wdata"}, wdata, 32'd0);
            chk({tag, "_clr_gid"}, 32'(grant_id), 32'd3);
            chk({tag, "_clr_init"}, 32'(init_done), (k == 31) ? 32'd1 : 32'd0);
            chk({tag, "_clr_ready"}, readies(), (k == 31) ? 32'(ready_at_end) : 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_reqs(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);

        // vector table, rr_ptr=0 at the start
        vecs.push_back('{"rot0", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0});
        vecs.push_back('{"rot1", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1});
        vecs.push_back('{"rot2", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2});
        vecs.push_back('{"rot3", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0});
        vecs.push_back('{"rot4", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1});
        vecs.push_back('{"rot5", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2});
        vecs.push_back('{"single1", 3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'h3F, 32'h0, 3'b010, 1'b1, 5'd5, 32'h3F, 2'd1});
        vecs.push_back('{"idle", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd5, 32'h3F, 2'd1});
        vecs.push_back('{"addr0", 3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFF, 3'b100, 1'b0, 5'd0, 32'h0, 2'd2});
        vecs.push_back('{"after0_a", 3'b101, 5'd4, 5'd0, 5'd6, 32'h44, 32'h0, 32'h66, 3'b001, 1'b1, 5'd4, 32'h44, 2'd0});
        vecs.push_back('{"after0_b", 3'b101, 5'd4, 5'd0, 5'd6, 32'h44, 32'h0, 32'h66, 3'b100, 1'b1, 5'd6, 32'h66, 2'd2});
        vecs.push_back('{"pair12", 3'b110, 5'd0, 5'd8, 5'd6, 32'h0, 32'h88, 32'h66, 3'b010, 1'b1, 5'd8, 32'h88, 2'd1});
        vecs.push_back('{"pair01", 3'b011, 5'd4, 5'd8, 5'd0, 32'h44, 32'h88, 32'h0, 3'b001, 1'b1, 5'd4, 32'h44, 2'd0});
        vecs.push_back('{"same_a", 3'b011, 5'd9, 5'd9, 5'd0, 32'hAA, 32'hBB, 32'h0, 3'b010, 1'b1, 5'd9, 32'hBB, 2'd1});
        vecs.push_back('{"same_b", 3'b001, 5'd9, 5'd0, 5'd0, 32'hAA, 32'h0, 32'h0, 3'b001, 1'b1, 5'd9, 32'hAA, 2'd0});
        vecs.push_back('{"idle2", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd9, 32'hAA, 2'd0});

        // reset values
        tick();
        tick();
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_init", 32'(init_done), 32'd0);
        chk("rst_ready", readies(), 32'd0);

        // clear with no requests, then port goes idle
        reset = 1'b0;
        run_clear("c1", 3'b000);
        tick();
        chk("post_clr_wen", 32'(wen), 32'd0);
        chk("post_clr_init", 32'(init_done), 32'd1);

        // table-driven arbitration
        foreach (vecs[i]) begin
            set_reqs(vecs[i].valid, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1,
                     vecs[i].a2, vecs[i].d2);
            #1;
            chk({vecs[i].name, "_ready"}, readies(), 32'(vecs[i].exp_ready));
            tick();
            chk({vecs[i].name, "_wen"}, 32'(wen), 32'(vecs[i].exp_wen));
            chk({vecs[i].name, "_gid"}, 32'(grant_id), 32'(vecs[i].exp_gid));
            if (vecs[i].exp_wen) begin
                chk({vecs[i].name, "_waddr"}, 32'(waddr), 32'(vecs[i].exp_waddr));
                chk({vecs[i].name, "_wdata"}, wdata, vecs[i].exp_wdata);
            end
        end
        set_reqs(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);

        // request held through the clear is served on the first ARB cycle
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (k == 9) set_reqs(3'b001, 5'd7, 32'hA5, 5'd0, 32'd0, 5'd0, 32'd0);
            if (k >= 10 && k < 31) chk("hold_ready_clr", 32'(req0_ready), 32'd0);
        end
        chk("hold_init", 32'(init_done), 32'd1);
        chk("hold_ready_arb", readies(), 32'b001);
        tick();
        set_reqs(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("hold_wen", 32'(wen), 32'd1);
        chk("hold_waddr", 32'(waddr), 32'd7);
        chk("hold_wdata", wdata, 32'hA5);
        chk("hold_gid", 32'(grant_id), 32'd0);
        tick();
        chk("hold_wen_off", 32'(wen), 32'd0);

        // reset in the middle of a req0/req1 stream (rr_ptr=1 here)
        set_reqs(3'b011, 5'd10, 32'h1, 5'd11, 32'h2, 5'd0, 32'd0);
        #1;
        chk("strm_ready_a", readies(), 32'b010);
        tick();
        chk("strm_waddr_a", 32'(waddr), 32'd11);
        chk("strm_gid_a", 32'(grant_id), 32'd1);
        chk("strm_ready_b", readies(), 32'b001);
        tick();
        chk("strm_waddr_b", 32'(waddr), 32'd10);
        chk("strm_gid_b", 32'(grant_id), 32'd0);
        reset = 1'b1;
        #1;
        chk("strm_rst_ready", readies(), 32'd0);
        tick();
        chk("strm_rst_wen", 32'(wen), 32'd0);
        chk("strm_rst_init", 32'(init_done), 32'd0);
        chk("strm_rst_gid", 32'(grant_id), 32'd0);
        chk("strm_rst_ready2", readies(), 32'd0);
        reset = 1'b0;
        run_clear("c3", 3'b001);
        tick();
        chk("strm_resume_wen", 32'(wen), 32'd1);
        chk("strm_resume_waddr", 32'(waddr), 32'd10);
        chk("strm_resume_gid", 32'(grant_id), 32'd0);
        set_reqs(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
